// File: rtl/frame_burst_responder_pkg.sv
// Shared constants and state encoding for the frame-buffer burst responder.
package frame_burst_responder_pkg;

    localparam int ADDR_WIDTH  = 23;
    localparam int BURST_WIDTH = 9;
    localparam int DATA_WIDTH  = 32;
    localparam int ROW_SIZE    = 80;

    typedef enum logic [1:0] {
        RESP_IDLE  = 2'd0,
        RESP_ISSUE = 2'd1,
        RESP_DRAIN = 2'd2
    } resp_state_e;

endpackage

// File: rtl/frame_burst_responder_slot.sv
// One-entry pending burst request register with full flag and sticky overrun flag.
module burst_request_slot #(
    parameter int ADDR_WIDTH  = frame_burst_responder_pkg::ADDR_WIDTH,
    parameter int BURST_WIDTH = frame_burst_responder_pkg::BURST_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [ADDR_WIDTH-1:0]  addr_i,
    input  logic [BURST_WIDTH-1:0] len_i,
    output logic                   full_o,
    output logic [ADDR_WIDTH-1:0]  addr_o,
    output logic [BURST_WIDTH-1:0] len_o,
    output logic                   overrun_o
);

    logic                   full_q, full_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [BURST_WIDTH-1:0] len_q, len_d;
    logic                   overrun_q, overrun_d;

    // A pop and a push in the same cycle refill the slot rather than dropping the push.
    always_comb begin
        full_d    = full_q;
        addr_d    = addr_q;
        len_d     = len_q;
        overrun_d = overrun_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (push_i) begin
            if (full_q && !pop_i) begin
                overrun_d = 1'b1;
            end else begin
                full_d = 1'b1;
                addr_d = addr_i;
                len_d  = len_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q    <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            overrun_q <= overrun_d;
        end
    end

    assign full_o    = full_q;
    assign addr_o    = addr_q;
    assign len_o     = len_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/frame_burst_responder.sv
// Burst-read responder: splits a frame-buffer burst into single-word memory reads and
// streams the returned words back in order.
//
// state      | meaning
// RESP_IDLE  | no burst active; launches a pending or new request
// RESP_ISSUE | reads remain to be issued to the memory port
// RESP_DRAIN | all reads issued, waiting for outstanding returns
module frame_burst_responder #(
    parameter int ADDR_WIDTH      = frame_burst_responder_pkg::ADDR_WIDTH,
    parameter int BURST_WIDTH     = frame_burst_responder_pkg::BURST_WIDTH,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd_request,
    input  logic [ADDR_WIDTH-1:0]  rd_address,
    input  logic [BURST_WIDTH-1:0] rd_burst_length,
    output logic                   rd_available,
    output logic [31:0]            rd_data,
    output logic                   rd_busy,
    output logic                   mem_read,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    input  logic                   mem_wait,
    input  logic                   mem_valid,
    input  logic [31:0]            mem_data,
    output logic                   overrun
);

    import frame_burst_responder_pkg::*;

    localparam int              OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    resp_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0]  issue_addr_q, issue_addr_d;
    logic [BURST_WIDTH-1:0] issue_left_q, issue_left_d;
    logic [BURST_WIDTH-1:0] return_left_q, return_left_d;
    logic [OUT_W-1:0]       outstanding_q, outstanding_d;
    logic                   rd_available_q, rd_available_d;
    logic [31:0]            rd_data_q, rd_data_d;

    logic                   slot_full;
    logic [ADDR_WIDTH-1:0]  slot_addr;
    logic [BURST_WIDTH-1:0] slot_len;
    logic                   slot_push;
    logic                   slot_pop;
    logic                   req_nonzero;
    logic                   launch_direct;
    logic                   launch_addr_sel;
    logic [ADDR_WIDTH-1:0]  launch_addr;
    logic [BURST_WIDTH-1:0] launch_len;
    logic                   can_issue;
    logic                   accept;
    logic                   ret;

    // Zero-length requests never reach the slot, so a popped entry always starts a burst.
    assign req_nonzero     = (rd_burst_length != '0);
    assign slot_pop        = (state_q == RESP_IDLE) && slot_full;
    assign slot_push       = rd_request && req_nonzero && ((state_q != RESP_IDLE) || slot_full);
    assign launch_direct   = (state_q == RESP_IDLE) && !slot_full && rd_request && req_nonzero;
    assign launch_addr_sel = slot_pop || launch_direct;
    assign launch_addr     = slot_full ? slot_addr : rd_address;
    assign launch_len      = slot_full ? slot_len  : rd_burst_length;

    assign can_issue = (state_q == RESP_ISSUE) && (outstanding_q < OUT_MAX) && (issue_left_q != '0);
    assign accept    = can_issue && !mem_wait;
    // Returns with nothing in flight belong to no read of ours.
    assign ret       = mem_valid && (outstanding_q != '0);

    burst_request_slot #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BURST_WIDTH (BURST_WIDTH)
    ) u_slot (
        .clk       (clk),
        .reset     (reset),
        .push_i    (slot_push),
        .pop_i     (slot_pop),
        .addr_i    (rd_address),
        .len_i     (rd_burst_length),
        .full_o    (slot_full),
        .addr_o    (slot_addr),
        .len_o     (slot_len),
        .overrun_o (overrun)
    );

    always_comb begin
        state_d        = state_q;
        issue_addr_d   = issue_addr_q;
        issue_left_d   = issue_left_q;
        return_left_d  = return_left_q;
        outstanding_d  = outstanding_q;
        rd_available_d = ret;
        rd_data_d      = ret ? mem_data : rd_data_q;

        case ({accept, ret})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (ret) begin
            return_left_d = return_left_q - BURST_WIDTH'(1);
        end

        case (state_q)
            RESP_IDLE: begin
                if (launch_addr_sel) begin
                    issue_addr_d  = launch_addr;
                    issue_left_d  = launch_len;
                    return_left_d = launch_len;
                    state_d       = RESP_ISSUE;
                end
            end
            RESP_ISSUE: begin
                if (accept) begin
                    issue_addr_d = issue_addr_q + ADDR_WIDTH'(1);
                    issue_left_d = issue_left_q - BURST_WIDTH'(1);
                    if (issue_left_q == BURST_WIDTH'(1)) begin
                        state_d = RESP_DRAIN;
                    end
                end
            end
            RESP_DRAIN: begin
                if (ret && (return_left_q == BURST_WIDTH'(1))) begin
                    state_d = RESP_IDLE;
                end
            end
            default: state_d = RESP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RESP_IDLE;
            issue_addr_q   <= '0;
            issue_left_q   <= '0;
            return_left_q  <= '0;
            outstanding_q  <= '0;
            rd_available_q <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            issue_addr_q   <= issue_addr_d;
            issue_left_q   <= issue_left_d;
            return_left_q  <= return_left_d;
            outstanding_q  <= outstanding_d;
            rd_available_q <= rd_available_d;
            rd_data_q      <= rd_data_d;
        end
    end

    assign rd_available = rd_available_q;
    assign rd_data      = rd_data_q;
    assign rd_busy      = (state_q != RESP_IDLE) || slot_full;
    assign mem_read     = can_issue;
    assign mem_address  = issue_addr_q;

endmodule

// File: tb/tb_frame_burst_responder.sv
// Self-checking bench: table-driven bursts against a variable-latency memory model,
// plus hand sequences for pending/overrun, stray returns and mid-burst reset.
module tb_frame_burst_responder;

    import frame_burst_responder_pkg::*;

    logic        clk;
    logic        reset;
    logic        rd_request;
    logic [22:0] rd_address;
    logic [8:0]  rd_burst_length;
    logic        rd_available;
    logic [31:0] rd_data;
    logic        rd_busy;
    logic        mem_read;
    logic [22:0] mem_address;
    logic        mem_wait;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        overrun;

    frame_burst_responder dut (
        .clk             (clk),
        .reset           (reset),
        .rd_request      (rd_request),
        .rd_address      (rd_address),
        .rd_burst_length (rd_burst_length),
        .rd_available    (rd_available),
        .rd_data         (rd_data),
        .rd_busy         (rd_busy),
        .mem_read        (mem_read),
        .mem_address     (mem_address),
        .mem_wait        (mem_wait),
        .mem_valid       (mem_valid),
        .mem_data        (mem_data),
        .overrun         (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [22:0] addr;
        logic [8:0]  len;
        int          lat;
        int          wait_pct;
        int          exp_words;
        logic [22:0] exp_first;
        logic [22:0] exp_last;
        bit          exp_sat;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } ret_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 2;
    int          pct = 0;
    logic [22:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    ret_t        retq[$];

    int          words, reads, max_inf, first_acc_cyc, last_acc_cyc;
    bit          seen_first, busy_at_last, hold_prev, stray_valid;
    logic [22:0] first_acc_addr, last_acc_addr, hold_addr;
    int          watch_words, watch_words_cyc, watch_read_cyc;
    bit          watch_busy;
    logic [22:0] watch_addr;
    bit          arm_req;
    logic [22:0] arm_addr;
    logic [8:0]  arm_len;

    function automatic logic [31:0] mdata(input logic [22:0] a);
        return {9'h155, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [22:0] addr, input logic [8:0] len);
        logic [22:0] a;
        for (int i = 0; i < int'(len); i++) begin
            a = addr + 23'(i);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(mdata(a));
        end
    endtask

    task automatic drive_req(input logic [22:0] addr, input logic [8:0] len);
        rd_request      = 1'b1;
        rd_address      = addr;
        rd_burst_length = len;
    endtask

    task automatic clear_stats();
        words = 0; reads = 0; max_inf = 0; seen_first = 0; busy_at_last = 0;
        first_acc_cyc = 0; last_acc_cyc = 0; first_acc_addr = '0; last_acc_addr = '0;
        watch_words = -1; watch_words_cyc = 0; watch_read_cyc = 0; watch_busy = 0;
        watch_addr = 23'h7FFFFF;
    endtask

    // One clock: observe outputs, then drive memory-side inputs for the next edge.
    task automatic tick();
        logic [22:0] ea;
        ret_t        r;
        @(posedge clk);
        #1;
        cyc++;
        rd_request = 1'b0;
        if (rd_available) begin
            check("avail_expected", 32'(exp_data_q.size() != 0), 32'd1);
            if (exp_data_q.size() != 0) check("rd_data", rd_data, exp_data_q.pop_front());
            words++;
            busy_at_last = rd_busy;
            if (words == watch_words) begin
                watch_words_cyc = cyc;
                watch_busy      = rd_busy;
            end
        end
        if (hold_prev && !reset) begin
            check("wait_hold_read", 32'(mem_read), 32'd1);
            check("wait_hold_addr", 32'(mem_address), 32'(hold_addr));
        end
        if (reset) begin
            mem_valid = 1'b0;
            mem_wait  = 1'b0;
            hold_prev = 1'b0;
            return;
        end
        mem_valid = 1'b0;
        if (retq.size() != 0 && retq[0].due <= cyc) begin
            mem_valid = 1'b1;
            mem_data  = retq[0].data;
            void'(retq.pop_front());
            if (arm_req && retq.size() == 0 && exp_addr_q.size() == 0) begin
                push_exp(arm_addr, arm_len);
                drive_req(arm_addr, arm_len);
                arm_req = 1'b0;
            end
        end else if (stray_valid) begin
            mem_valid = 1'b1;
            mem_data  = 32'hDEADBEEF;
        end
        mem_wait = (pct > 0) && (int'($urandom_range(99)) < pct);
        if (mem_read && !mem_wait) begin
            check("read_expected", 32'(exp_addr_q.size() != 0), 32'd1);
            if (exp_addr_q.size() != 0) begin
                ea = exp_addr_q.pop_front();
                check("mem_address", 32'(mem_address), 32'(ea));
            end
            r.due  = cyc + lat;
            r.data = mdata(mem_address);
            retq.push_back(r);
            if (!seen_first) begin
                seen_first     = 1'b1;
                first_acc_cyc  = cyc;
                first_acc_addr = mem_address;
            end
            last_acc_cyc  = cyc;
            last_acc_addr = mem_address;
            if (mem_address == watch_addr) watch_read_cyc = cyc;
            reads++;
        end
        if (retq.size() > max_inf) max_inf = retq.size();
        hold_prev = mem_read && mem_wait;
        hold_addr = mem_address;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (exp_addr_q.size() == 0 && exp_data_q.size() == 0 && retq.size() == 0 && !rd_busy) begin
                done = 1'b1;
                break;
            end
        end
        check("idle_reached", 32'(done), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        lat = v.lat;
        pct = v.wait_pct;
        clear_stats();
        push_exp(v.addr, v.len);
        drive_req(v.addr, v.len);
        tick();
        check("busy_after_req", 32'(rd_busy), 32'(v.len != 0));
        check("read_after_req", 32'(mem_read), 32'(v.len != 0));
        wait_idle(3000);
        check("words", 32'(words), 32'(v.exp_words));
        check("reads", 32'(reads), 32'(v.exp_words));
        if (v.exp_words > 0) begin
            check("first_addr", 32'(first_acc_addr), 32'(v.exp_first));
            check("last_addr", 32'(last_acc_addr), 32'(v.exp_last));
            check("busy_at_last_pulse", 32'(busy_at_last), 32'd0);
        end
        check("max_inflight_le_4", 32'(max_inf <= 4), 32'd1);
        if (v.exp_sat) check("max_inflight_sat", 32'(max_inf), 32'd4);
        if (v.wait_pct == 0 && !v.exp_sat && v.exp_words > 0)
            check("issue_span", 32'(last_acc_cyc - first_acc_cyc), 32'(v.exp_words - 1));
        check("rd_busy_end", 32'(rd_busy), 32'd0);
    endtask

    vec_t vecs[7];
    vec_t post_rst;
    bit   queued;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{23'h000100, 9'(ROW_SIZE), 2,  0,  80, 23'h000100, 23'h00014F, 1'b0};
        vecs[1] = '{23'h000100, 9'(ROW_SIZE), 10, 0,  80, 23'h000100, 23'h00014F, 1'b1};
        vecs[2] = '{23'h002000, 9'(ROW_SIZE), 3,  50, 80, 23'h002000, 23'h00204F, 1'b0};
        vecs[3] = '{23'h7FFFFE, 9'd4,         2,  0,  4,  23'h7FFFFE, 23'h000001, 1'b0};
        vecs[4] = '{23'h012345, 9'd0,         2,  0,  0,  23'h000000, 23'h000000, 1'b0};
        vecs[5] = '{23'h000055, 9'd1,         1,  0,  1,  23'h000055, 23'h000055, 1'b0};
        vecs[6] = '{23'h7FFF00, 9'd511,       4,  25, 511, 23'h7FFF00, 23'h0000FE, 1'b0};
        post_rst = '{23'h0002A0, 9'd16,       2,  0,  16, 23'h0002A0, 23'h0002AF, 1'b0};

        reset = 1'b1; rd_request = 1'b0; rd_address = '0; rd_burst_length = '0;
        mem_wait = 1'b0; mem_valid = 1'b0; mem_data = '0;
        hold_prev = 0; stray_valid = 0; arm_req = 0; arm_addr = '0; arm_len = '0;
        clear_stats();
        tick(); tick();
        check("rst_rd_available", 32'(rd_available), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_rd_busy", 32'(rd_busy), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        tick();

        for (int k = 0; k < 7; k++) run_vec(vecs[k]);
        check("overrun_clear", 32'(overrun), 32'd0);

        // Stray returns with nothing in flight must be ignored.
        stray_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stray_avail", 32'(rd_available), 32'd0);
        end
        stray_valid = 1'b0;
        tick();
        check("stray_avail_tail", 32'(rd_available), 32'd0);

        // Queued request follows immediately; a third request is dropped.
        lat = 3; pct = 0;
        clear_stats();
        watch_words = 8;
        watch_addr  = 23'h000400;
        push_exp(23'h000300, 9'd8);
        drive_req(23'h000300, 9'd8);
        tick();
        push_exp(23'h000400, 9'd5);
        drive_req(23'h000400, 9'd5);
        tick();
        check("overrun_after_queue", 32'(overrun), 32'd0);
        check("busy_queued", 32'(rd_busy), 32'd1);
        drive_req(23'h000500, 9'd3);
        tick();
        check("overrun_after_drop", 32'(overrun), 32'd1);
        wait_idle(2000);
        check("pending_words", 32'(words), 32'd13);
        check("pending_gap", 32'(watch_read_cyc - watch_words_cyc), 32'd1);
        check("busy_held_for_pending", 32'(watch_busy), 32'd1);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Request arriving with the final return of a burst is kept, not dropped.
        lat = 2; pct = 0;
        clear_stats();
        arm_req = 1'b1; arm_addr = 23'h000640; arm_len = 9'd3;
        push_exp(23'h000600, 9'd6);
        drive_req(23'h000600, 9'd6);
        tick();
        wait_idle(2000);
        check("end_cycle_req_fired", 32'(arm_req), 32'd0);
        check("end_cycle_words", 32'(words), 32'd9);
        check("end_cycle_last_addr", 32'(last_acc_addr), 32'h642);

        // Reset at word 40 of 80 with a request parked in the pending slot.
        lat = 2; pct = 0;
        clear_stats();
        queued = 1'b0;
        push_exp(23'h001000, 9'(ROW_SIZE));
        drive_req(23'h001000, 9'(ROW_SIZE));
        for (int i = 0; i < 1000 && words < 40; i++) begin
            tick();
            if (words >= 20 && !queued) begin
                drive_req(23'h006000, 9'd5);
                queued = 1'b1;
            end
        end
        check("reached_word_40", 32'(words), 32'd40);
        reset = 1'b1;
        exp_addr_q.delete(); exp_data_q.delete(); retq.delete();
        mem_valid = 1'b0;
        tick();
        check("mid_rst_rd_available", 32'(rd_available), 32'd0);
        check("mid_rst_rd_data", rd_data, 32'd0);
        check("mid_rst_rd_busy", 32'(rd_busy), 32'd0);
        check("mid_rst_mem_read", 32'(mem_read), 32'd0);
        check("mid_rst_mem_address", 32'(mem_address), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_idle_read", 32'(mem_read), 32'd0);
            check("post_rst_idle_busy", 32'(rd_busy), 32'd0);
        end
        run_vec(post_rst);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
